sweep_result_collector: RTL and testbench

//  Consumer end of the sweep measurement stream: captures every (MODULO, PHASE, address) result that the sweep

---
 rtl/sweep_pkg.sv | 19 +
 rtl/result_ram.sv | 33 +++
 rtl/sweep_result_collector.sv | 179 +++++++++++++++++
 tb/tb_sweep_result_collector.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/sweep_pkg.sv
// Shared types and constants for the sweep result collector.
//  coll_state_t : collector FSM states
//  WSEL_*       : read-address word select (LSB of rd_addr)
//  DEF_*        : default data and frequency-index widths
package sweep_pkg;

   localparam int unsigned DEF_DATA_WIDTH = 32;
   localparam int unsigned DEF_ADDR_WIDTH = 8;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_COLLECT = 2'd1,
      ST_DONE    = 2'd2
   } coll_state_t;

   localparam logic WSEL_MODULO = 1'b0;
   localparam logic WSEL_PHASE  = 1'b1;

endpackage : sweep_pkg

// File: rtl/result_ram.sv
// Simple dual-port result table, one write port and one registered read port.
// A read and a write to the same address in one cycle return the old contents.
//  clk       : clock
//  wr_en_i   : write strobe
//  wr_addr_i : write address
//  wr_data_i : write word
//  rd_addr_i : read address, sampled every cycle
//  rd_data_o : read word, one cycle after rd_addr_i
module result_ram #(
   parameter int unsigned WIDTH      = 64,
   parameter int unsigned ADDR_WIDTH = 8
) (
   input  logic                  clk,
   input  logic                  wr_en_i,
   input  logic [ADDR_WIDTH-1:0] wr_addr_i,
   input  logic [WIDTH-1:0]      wr_data_i,
   input  logic [ADDR_WIDTH-1:0] rd_addr_i,
   output logic [WIDTH-1:0]      rd_data_o
);

   localparam int unsigned DEPTH = 1 << ADDR_WIDTH;

   logic [WIDTH-1:0] mem_q [DEPTH];

   // Storage has no reset; validity is tracked outside the array.
   always_ff @(posedge clk) begin
      if (wr_en_i) begin
         mem_q[wr_addr_i] <= wr_data_i;
      end
      rd_data_o <= mem_q[rd_addr_i];
   end

endmodule : result_ram

// File: rtl/sweep_result_collector.sv
// Captures sweep controller results into a table indexed by frequency address
// and serves them to the register bus with a fixed two-cycle read latency.
//  clk125, areset_n      : clock, asynchronous active-low reset
//  start, sweep_fin      : sweep start level, sweep complete level
//  valid_m, modulo,
//  phase, index          : result strobe and payload from the sweep controller
//  rd_req, rd_addr       : bus read request, {entry index, word select}
//  rd_ack, rd_data       : read data strobe and word (zero when not acked)
//  count                 : distinct entries written this sweep
//  done                  : sweep collected, table stable
//  dup_err, lost_err     : sticky duplicate-index and out-of-sweep result flags
module sweep_result_collector
   import sweep_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
   parameter int unsigned ADDR_WIDTH = DEF_ADDR_WIDTH
) (
   input  logic                  clk125,
   input  logic                  areset_n,
   input  logic                  start,
   input  logic                  sweep_fin,
   input  logic                  valid_m,
   input  logic [DATA_WIDTH-1:0] modulo,
   input  logic [DATA_WIDTH-1:0] phase,
   input  logic [ADDR_WIDTH-1:0] index,
   input  logic                  rd_req,
   input  logic [ADDR_WIDTH:0]   rd_addr,
   output logic                  rd_ack,
   output logic [DATA_WIDTH-1:0] rd_data,
   output logic [ADDR_WIDTH:0]   count,
   output logic                  done,
   output logic                  dup_err,
   output logic                  lost_err
);

   localparam int unsigned DEPTH      = 1 << ADDR_WIDTH;
   localparam int unsigned CNT_WIDTH  = ADDR_WIDTH + 1;
   localparam int unsigned WORD_WIDTH = 2 * DATA_WIDTH;
   localparam logic [CNT_WIDTH-1:0] COUNT_MAX = CNT_WIDTH'(DEPTH);

   coll_state_t           state_q, state_d;
   logic                  start_q;
   logic [DEPTH-1:0]      valid_q, valid_d;
   logic [CNT_WIDTH-1:0]  count_q, count_d;
   logic                  done_q, done_d;
   logic                  dup_q, dup_d;
   logic                  lost_q, lost_d;

   logic                  rd_req_q;
   logic                  rd_wsel_q;
   logic                  rd_vld_q;
   logic                  rd_ack_q;
   logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d;

   logic                  start_rise_c;
   logic                  wr_en_c;
   logic [ADDR_WIDTH-1:0] rd_entry_c;
   logic [WORD_WIDTH-1:0] ram_rdata;
   logic [DATA_WIDTH-1:0] word_c;

   assign start_rise_c = start & ~start_q;
   assign rd_entry_c   = rd_addr[ADDR_WIDTH:1];

   result_ram #(
      .WIDTH      (WORD_WIDTH),
      .ADDR_WIDTH (ADDR_WIDTH)
   ) u_ram (
      .clk       (clk125),
      .wr_en_i   (wr_en_c),
      .wr_addr_i (index),
      .wr_data_i ({modulo, phase}),
      .rd_addr_i (rd_entry_c),
      .rd_data_o (ram_rdata)
   );

   // Collector FSM next state: bookkeeping for writes, flags and sweep boundaries.
   always_comb begin
      state_d = state_q;
      valid_d = valid_q;
      count_d = count_q;
      done_d  = done_q;
      dup_d   = dup_q;
      lost_d  = lost_q;
      wr_en_c = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (start_rise_c) begin
               // A new sweep wipes the previous bookkeeping on the start edge.
               state_d = ST_COLLECT;
               valid_d = '0;
               count_d = '0;
               done_d  = 1'b0;
               dup_d   = 1'b0;
               lost_d  = 1'b0;
            end else if (valid_m) begin
               lost_d = 1'b1;
            end
         end
         ST_COLLECT: begin
            if (valid_m) begin
               wr_en_c        = 1'b1;
               valid_d[index] = 1'b1;
               if (valid_q[index]) begin
                  dup_d = 1'b1;
               end else if (count_q != COUNT_MAX) begin
                  count_d = count_q + CNT_WIDTH'(1);
               end
            end
            // A result arriving with sweep_fin is still taken above.
            if (sweep_fin) begin
               state_d = ST_DONE;
               done_d  = 1'b1;
            end
         end
         ST_DONE: begin
            if (valid_m) begin
               lost_d = 1'b1;
            end
            if (!start) begin
               state_d = ST_IDLE;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // Word select on the RAM output; unwritten entries read as zero.
   always_comb begin
      word_c = ram_rdata[WORD_WIDTH-1:DATA_WIDTH];
      case (rd_wsel_q)
         WSEL_MODULO: word_c = ram_rdata[WORD_WIDTH-1:DATA_WIDTH];
         WSEL_PHASE:  word_c = ram_rdata[DATA_WIDTH-1:0];
         default:     word_c = ram_rdata[WORD_WIDTH-1:DATA_WIDTH];
      endcase
      rd_data_d = (rd_req_q && rd_vld_q) ? word_c : '0;
   end

   // State, bookkeeping and two-stage read pipeline registers.
   always_ff @(posedge clk125 or negedge areset_n) begin
      if (!areset_n) begin
         state_q   <= ST_IDLE;
         start_q   <= 1'b0;
         valid_q   <= '0;
         count_q   <= '0;
         done_q    <= 1'b0;
         dup_q     <= 1'b0;
         lost_q    <= 1'b0;
         rd_req_q  <= 1'b0;
         rd_wsel_q <= 1'b0;
         rd_vld_q  <= 1'b0;
         rd_ack_q  <= 1'b0;
         rd_data_q <= '0;
      end else begin
         state_q   <= state_d;
         start_q   <= start;
         valid_q   <= valid_d;
         count_q   <= count_d;
         done_q    <= done_d;
         dup_q     <= dup_d;
         lost_q    <= lost_d;
         rd_req_q  <= rd_req;
         rd_wsel_q <= rd_addr[0];
         // Pre-write valid bit, matching the read-first RAM data of the same edge.
         rd_vld_q  <= valid_q[rd_entry_c];
         rd_ack_q  <= rd_req_q;
         rd_data_q <= rd_data_d;
      end
   end

   assign rd_ack   = rd_ack_q;
   assign rd_data  = rd_data_q;
   assign count    = count_q;
   assign done     = done_q;
   assign dup_err  = dup_q;
   assign lost_err = lost_q;

endmodule : sweep_result_collector

// File: tb/tb_sweep_result_collector.sv
// Directed bench for sweep_result_collector: sweep capture, duplicate and lost
// results, read latency and read-first collision, sweep restart, async reset.
module tb_sweep_result_collector;

   localparam int unsigned DW = 32;
   localparam int unsigned AW = 8;

   logic          clk125;
   logic          areset_n;
   logic          start;
   logic          sweep_fin;
   logic          valid_m;
   logic [DW-1:0] modulo;
   logic [DW-1:0] phase;
   logic [AW-1:0] index;
   logic          rd_req;
   logic [AW:0]   rd_addr;
   logic          rd_ack;
   logic [DW-1:0] rd_data;
   logic [AW:0]   count;
   logic          done;
   logic          dup_err;
   logic          lost_err;

   int checks   = 0;
   int failures = 0;

   sweep_result_collector #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
      .clk125   (clk125),
      .areset_n (areset_n),
      .start    (start),
      .sweep_fin(sweep_fin),
      .valid_m  (valid_m),
      .modulo   (modulo),
      .phase    (phase),
      .index    (index),
      .rd_req   (rd_req),
      .rd_addr  (rd_addr),
      .rd_ack   (rd_ack),
      .rd_data  (rd_data),
      .count    (count),
      .done     (done),
      .dup_err  (dup_err),
      .lost_err (lost_err)
   );

   initial clk125 = 1'b0;
   always #4 clk125 = ~clk125;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   // ---------------- stimulus helpers (no checking) ----------------
   task automatic write_entry(input int idx, input logic [DW-1:0] m, input logic [DW-1:0] p);
      @(negedge clk125);
      valid_m = 1'b1; index = AW'(idx); modulo = m; phase = p;
      @(negedge clk125);
      valid_m = 1'b0;
   endtask

   task automatic start_sweep();
      @(negedge clk125);
      start = 1'b1;
      @(negedge clk125);
   endtask

   task automatic finish_sweep();
      @(negedge clk125);
      sweep_fin = 1'b1;
      @(negedge clk125);
      sweep_fin = 1'b0;
   endtask

   task automatic drop_start();
      @(negedge clk125);
      start = 1'b0;
      @(negedge clk125);
   endtask

   // Single read: returns ack one cycle after the edge that sampled rd_req,
   // then ack and data two cycles after it.
   task automatic bus_read(input logic [AW:0] a, output logic early_ack,
                           output logic ack, output logic [DW-1:0] data);
      @(negedge clk125);
      rd_req = 1'b1; rd_addr = a;
      @(negedge clk125);
      rd_req = 1'b0;
      early_ack = rd_ack;
      @(negedge clk125);
      ack  = rd_ack;
      data = rd_data;
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      areset_n = 1'b0; start = 1'b0; sweep_fin = 1'b0; valid_m = 1'b0;
      modulo = '0; phase = '0; index = '0; rd_req = 1'b0; rd_addr = '0;
      repeat (3) @(negedge clk125);
      areset_n = 1'b1;
      @(negedge clk125);
      checks++; if ({rd_ack, rd_data, count, done, dup_err, lost_err} !== '0) begin
         failures++; $display("FAIL reset_outputs: got ack=%0b data=%0h count=%0d done=%0b dup=%0b lost=%0b required all 0",
                              rd_ack, rd_data, count, done, dup_err, lost_err);
      end
   endtask

   task automatic test_basic_sweep();
      logic e, a; logic [DW-1:0] d;
      start_sweep();
      for (int i = 0; i < 4; i++) write_entry(i, DW'(100 + i), DW'(-i));
      finish_sweep();
      checks++; if (count !== 9'd4) begin failures++; $display("FAIL basic_count: got %0d required 4", count); end
      checks++; if (done !== 1'b1) begin failures++; $display("FAIL basic_done: got %0b required 1", done); end
      checks++; if ({dup_err, lost_err} !== 2'b00) begin failures++; $display("FAIL basic_flags: got dup=%0b lost=%0b required 0 0", dup_err, lost_err); end
      bus_read({8'd2, 1'b0}, e, a, d);
      checks++; if (e !== 1'b0) begin failures++; $display("FAIL basic_ack_early: got %0b required 0", e); end
      checks++; if (a !== 1'b1) begin failures++; $display("FAIL basic_ack_mod: got %0b required 1", a); end
      checks++; if (d !== 32'd102) begin failures++; $display("FAIL basic_read_mod: got %0h required 66", d); end
      bus_read({8'd2, 1'b1}, e, a, d);
      checks++; if (a !== 1'b1 || d !== 32'hFFFF_FFFE) begin failures++; $display("FAIL basic_read_ph: got ack=%0b data=%0h required ack=1 data=fffffffe", a, d); end
      bus_read({8'd7, 1'b0}, e, a, d);
      checks++; if (a !== 1'b1 || d !== 32'd0) begin failures++; $display("FAIL basic_read_unwritten: got ack=%0b data=%0h required ack=1 data=0", a, d); end
      @(negedge clk125);
      checks++; if (rd_ack !== 1'b0 || rd_data !== 32'd0) begin failures++; $display("FAIL basic_idle_bus: got ack=%0b data=%0h required 0 0", rd_ack, rd_data); end
      drop_start();
      checks++; if (done !== 1'b1) begin failures++; $display("FAIL basic_done_idle: got %0b required 1", done); end
   endtask

   task automatic test_dup();
      logic e, a; logic [DW-1:0] d;
      start_sweep();
      write_entry(5, 32'd7, 32'd70);
      write_entry(5, 32'd9, 32'd90);
      checks++; if (count !== 9'd1) begin failures++; $display("FAIL dup_count: got %0d required 1", count); end
      checks++; if (dup_err !== 1'b1) begin failures++; $display("FAIL dup_flag: got %0b required 1", dup_err); end
      bus_read({8'd5, 1'b0}, e, a, d);
      checks++; if (a !== 1'b1 || d !== 32'd9) begin failures++; $display("FAIL dup_read: got ack=%0b data=%0h required ack=1 data=9", a, d); end
      finish_sweep();
      drop_start();
   endtask

   task automatic test_lost();
      logic e, a; logic [DW-1:0] d;
      checks++; if (lost_err !== 1'b0) begin failures++; $display("FAIL lost_pre: got %0b required 0", lost_err); end
      write_entry(3, 32'd55, 32'd56);
      checks++; if (lost_err !== 1'b1) begin failures++; $display("FAIL lost_flag: got %0b required 1", lost_err); end
      checks++; if (count !== 9'd1) begin failures++; $display("FAIL lost_count: got %0d required 1", count); end
      bus_read({8'd3, 1'b0}, e, a, d);
      checks++; if (a !== 1'b1 || d !== 32'd0) begin failures++; $display("FAIL lost_read: got ack=%0b data=%0h required ack=1 data=0", a, d); end
   endtask

   task automatic test_second_sweep();
      logic e, a; logic [DW-1:0] d;
      start_sweep();
      checks++; if ({count, done, dup_err, lost_err} !== '0) begin
         failures++; $display("FAIL restart_clear: got count=%0d done=%0b dup=%0b lost=%0b required all 0", count, done, dup_err, lost_err);
      end
      bus_read({8'd5, 1'b0}, e, a, d);
      checks++; if (a !== 1'b1 || d !== 32'd0) begin failures++; $display("FAIL restart_stale: got ack=%0b data=%0h required ack=1 data=0", a, d); end
      write_entry(5, 32'd11, 32'd12);
      bus_read({8'd5, 1'b0}, e, a, d);
      checks++; if (d !== 32'd11) begin failures++; $display("FAIL restart_rewrite: got %0h required b", d); end
   endtask

   task automatic test_back_to_back();
      logic [AW:0]   addrs [4];
      logic [DW-1:0] exp   [4];
      addrs[0] = {8'd8, 1'b0}; addrs[1] = {8'd8, 1'b1};
      addrs[2] = {8'd9, 1'b0}; addrs[3] = {8'd9, 1'b1};
      // first read collides with the overwrite of entry 8 and sees the old word
      exp[0] = 32'd20; exp[1] = 32'd31; exp[2] = 32'd40; exp[3] = 32'd41;
      write_entry(8, 32'd20, 32'd21);
      write_entry(9, 32'd40, 32'd41);
      for (int c = 0; c < 7; c++) begin
         @(negedge clk125);
         if (c >= 2 && c < 6) begin
            checks++; if (rd_ack !== 1'b1 || rd_data !== exp[c-2]) begin
               failures++; $display("FAIL b2b_read%0d: got ack=%0b data=%0h required ack=1 data=%0h", c - 2, rd_ack, rd_data, exp[c-2]);
            end
         end
         if (c == 6) begin
            checks++; if (rd_ack !== 1'b0 || rd_data !== 32'd0) begin
               failures++; $display("FAIL b2b_tail: got ack=%0b data=%0h required 0 0", rd_ack, rd_data);
            end
         end
         rd_req  = (c < 4);
         rd_addr = (c < 4) ? addrs[c] : '0;
         valid_m = (c == 0);
         index   = 8'd8; modulo = 32'd30; phase = 32'd31;
      end
      checks++; if (count !== 9'd3 || dup_err !== 1'b1) begin
         failures++; $display("FAIL b2b_count: got count=%0d dup=%0b required count=3 dup=1", count, dup_err);
      end
      finish_sweep();
      drop_start();
   endtask

   task automatic test_async_reset();
      logic e, a; logic [DW-1:0] d;
      start_sweep();
      for (int i = 10; i < 20; i++) write_entry(i, DW'(200 + i), DW'(i));
      checks++; if (count !== 9'd10) begin failures++; $display("FAIL arst_precount: got %0d required 10", count); end
      // leave a read in flight so the pipeline is non-zero at reset
      @(negedge clk125);
      rd_req = 1'b1; rd_addr = {8'd12, 1'b0}; start = 1'b0;
      @(negedge clk125);
      @(posedge clk125);
      #2 areset_n = 1'b0;
      #1;
      checks++; if ({rd_ack, rd_data, count, done, dup_err, lost_err} !== '0) begin
         failures++; $display("FAIL arst_outputs: got ack=%0b data=%0h count=%0d done=%0b dup=%0b lost=%0b required all 0",
                              rd_ack, rd_data, count, done, dup_err, lost_err);
      end
      rd_req = 1'b0;
      @(negedge clk125);
      areset_n = 1'b1;
      bus_read({8'd12, 1'b0}, e, a, d);
      checks++; if (a !== 1'b1 || d !== 32'd0) begin failures++; $display("FAIL arst_read: got ack=%0b data=%0h required ack=1 data=0", a, d); end
      write_entry(4, 32'd1, 32'd2);
      checks++; if (lost_err !== 1'b1 || count !== 9'd0) begin
         failures++; $display("FAIL arst_idle: got lost=%0b count=%0d required lost=1 count=0", lost_err, count);
      end
   endtask

   task automatic test_fin_with_valid();
      logic e, a; logic [DW-1:0] d;
      start_sweep();
      @(negedge clk125);
      checks++; if (done !== 1'b0) begin failures++; $display("FAIL finv_done_before: got %0b required 0", done); end
      valid_m = 1'b1; index = 8'd30; modulo = 32'd77; phase = 32'd78; sweep_fin = 1'b1;
      @(negedge clk125);
      valid_m = 1'b0; sweep_fin = 1'b0;
      checks++; if (done !== 1'b1 || count !== 9'd1) begin
         failures++; $display("FAIL finv_done: got done=%0b count=%0d required done=1 count=1", done, count);
      end
      bus_read({8'd30, 1'b0}, e, a, d);
      checks++; if (a !== 1'b1 || d !== 32'd77) begin failures++; $display("FAIL finv_read: got ack=%0b data=%0h required ack=1 data=4d", a, d); end
      drop_start();
   endtask

   initial begin
      test_reset();
      test_basic_sweep();
      test_dup();
      test_lost();
      test_second_sweep();
      test_back_to_back();
      test_async_reset();
      test_fin_with_valid();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule : tb_sweep_result_collector
